mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream controller for the 4-to-1 select mux (3-bit data). It drives the
//   mux select lines s1/s0 and steps round-robin through the enabled channels.
//   For each channel it waits a settle interval and captures the mux output.
//   Each captured sample, with its channel index, goes out on a valid/ready
//   handshake. A done pulse marks the end of each scan.
// PARAMETERS
//   DATA_W      3   width of mux data path (mux_out, data_out)
//   SETTLE_CYC  2   cycles select is held before capture; legal range 1..15
// PORTS
//   clock       in   1       single clock, all logic on rising edge
//   reset_n     in   1       synchronous, active-low reset
//   start       in   1       begin a scan; sampled only in IDLE
//   chan_mask   in   4       channel enables, bit n = mux input n; sampled with start
//   mux_out     in   DATA_W  output of the 4-to-1 mux
//   s1          out  1       mux select MSB (registered)
//   s0          out  1       mux select LSB (registered)
//   data_out    out  DATA_W  captured sample
//   chan_out    out  2       channel index of data_out
//   data_valid  out  1       data_out/chan_out valid
//   data_ready  in   1       consumer accepts when data_valid & data_ready
//   busy        out  1       scan in progress
//   done        out  1       one-cycle pulse, scan complete
// BEHAVIOUR
//   - Reset (reset_n=0 at an edge): state=IDLE. All outputs are 0: s1, s0,
//     data_out, chan_out, data_valid, busy, done. Settle counter=0. The stored
//     mask is cleared. Reset wins over every other event, including mid-scan
//     and mid-handshake. Any held sample is discarded.
//   - States:
//     - IDLE -> SETTLE on start with chan_mask!=0.
//     - SETTLE -> HOLD after SETTLE_CYC edges.
//     - HOLD -> SETTLE on accept when a higher enabled channel remains.
//     - HOLD -> IDLE on accept when no higher enabled channel remains.
//   - Start edge k, IDLE, mask!=0:
//     - Register the mask.
//     - {s1,s0} <= lowest enabled channel. busy <= 1. cnt <= 0.
//   - Start in IDLE with mask==0: done <= 1 for one cycle. busy stays 0.
//     No data is produced.
//   - start outside IDLE is ignored. Mask changes during a scan are ignored.
//   - SETTLE:
//     - cnt increments each edge.
//     - At the edge where cnt==SETTLE_CYC-1: data_out <= mux_out,
//       chan_out <= {s1,s0}, data_valid <= 1, go to HOLD.
//     - Result: data_valid rises at edge k+SETTLE_CYC.
//   - HOLD:
//     - data_out, chan_out, s1 and s0 are stable while data_valid=1 and
//       data_ready=0 (AXI-style; no retraction).
//     - Accept edge j, next enabled channel exists (ascending index, no wrap):
//       data_valid <= 0, {s1,s0} <= next, cnt <= 0, go to SETTLE.
//       Next data_valid rises at edge j+SETTLE_CYC.
//     - Accept edge j, last enabled channel: data_valid <= 0, busy <= 0,
//       done <= 1 for exactly one cycle, go to IDLE. s1/s0 keep their last value.
//   - done is never asserted in the same cycle as data_valid.
//   - start and done may coincide in IDLE. Start is honoured because the
//     state is already IDLE.
//   - Disabled channels are skipped with no idle cycles.
//   - Throughput: SETTLE_CYC+1 cycles per sample when data_ready is held at 1.
// TESTING
//   Bench wiring: mux inputs i0..i3 = 1,2,3,4; SETTLE_CYC=2.
//   1. Full scan, mask=4'b1111, data_ready=1.
//      -> 4 samples (chan,data) = (0,1),(1,2),(2,3),(3,4).
//      -> First data_valid at edge k+2. Samples 3 cycles apart.
//      -> done is a single pulse after the 4th accept.
//   2. Sparse scan, mask=4'b1010.
//      -> Only (1,2) then (3,4). Channels 0 and 2 are never driven on s1/s0.
//   3. Backpressure: data_ready=0 for 5 cycles on the first sample.
//      -> data_valid, data_out=1, chan_out=0 and s1/s0 held stable.
//      -> Scan resumes on the accept edge.
//   4. mask=0 with start.
//      -> done pulses one cycle. busy=0. data_valid never rises.
//   5. start pulsed mid-scan, and chan_mask changed mid-scan.
//      -> No effect; the original scan completes unchanged.
//   6. reset_n=0 for one edge while in HOLD of channel 2.
//      -> All outputs 0 and IDLE next cycle.
//      -> A new start scans from the lowest enabled channel.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for a 4-to-1 mux: drives the select lines,
// waits a settle interval per channel and streams (channel, sample) pairs out over valid/ready.
module mux_scan_sequencer #(
  parameter int DATA_W     = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        chan_mask,
  input  logic [DATA_W-1:0] mux_out,
  output logic              s1,
  output logic              s0,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        chan_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t            state_q;
  logic [3:0]        mask_q;
  logic [1:0]        sel_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        chan_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        first_sel_d;
  logic [1:0]        next_sel_d;
  logic              has_next_d;

  // Lowest enabled channel of the incoming mask picks the first select value.
  always_comb begin
    first_sel_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i]) first_sel_d = 2'(i);
    end
  end

  // Next enabled channel strictly above the current one; no wrap-around.
  always_comb begin
    has_next_d = 1'b0;
    next_sel_d = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (2'(i) > sel_q)) begin
        has_next_d = 1'b1;
        next_sel_d = 2'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= 4'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      data_q  <= '0;
      chan_q  <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (chan_mask != 4'd0) begin
              mask_q  <= chan_mask;
              sel_q   <= first_sel_d;
              busy_q  <= 1'b1;
              cnt_q   <= 4'd0;
              state_q <= SETTLE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            data_q  <= mux_out;
            chan_q  <= sel_q;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Everything stays frozen until the consumer takes the sample.
          if (data_ready) begin
            valid_q <= 1'b0;
            if (has_next_d) begin
              sel_q   <= next_sel_d;
              cnt_q   <= 4'd0;
              state_q <= SETTLE;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s1         = sel_q[1];
  assign s0         = sel_q[0];
  assign data_out   = data_q;
  assign chan_out   = chan_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized bench for mux_scan_sequencer: a per-scan list of expected
// (channel, sample) pairs plus timing rules is checked cycle by cycle.
module tb_mux_scan_sequencer;

  localparam int DATA_W     = 3;
  localparam int SETTLE_CYC = 2;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic [3:0]        chan_mask;
  logic [DATA_W-1:0] mux_out;
  logic              s1;
  logic              s0;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        chan_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mux_in [4];
  logic [1:0]        sel;
  logic              noise;
  int                total;
  int                bad;

  mux_scan_sequencer #(
    .DATA_W     (DATA_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .chan_mask  (chan_mask),
    .mux_out    (mux_out),
    .s1         (s1),
    .s0         (s0),
    .data_out   (data_out),
    .chan_out   (chan_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  assign sel     = {s1, s0};
  assign mux_out = mux_in[sel];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic tick;
    if (noise) begin
      start     = 1'($urandom_range(0, 1));
      chan_mask = 4'($urandom);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   32'(sel), 32'd0);
    check({tag, "_data"},  32'(data_out), 32'd0);
    check({tag, "_chan"},  32'(chan_out), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  // One complete scan. abort_chan in 0..3 resets the DUT while that channel is held.
  task automatic run_scan(input logic [3:0] mask, input int stall_lo, input int stall_hi,
                          input bit perturb, input int abort_chan);
    int exp_ch[$];
    int ch;
    int stall;
    bit last;
    for (int i = 0; i < 4; i++) if (mask[i]) exp_ch.push_back(i);
    $display("scan mask=%b in=%0d,%0d,%0d,%0d perturb=%0d abort=%0d", mask,
             mux_in[0], mux_in[1], mux_in[2], mux_in[3], perturb, abort_chan);
    noise      = 1'b0;
    data_ready = 1'b0;
    chan_mask  = mask;
    start      = 1'b1;
    tick();
    start = 1'b0;
    noise = perturb;
    if (exp_ch.size() == 0) begin
      noise = 1'b0;
      check("empty_done", 32'(done), 32'd1);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_valid", 32'(data_valid), 32'd0);
      tick();
      check("empty_done_pulse", 32'(done), 32'd0);
      check("empty_valid2", 32'(data_valid), 32'd0);
      return;
    end
    for (int idx = 0; idx < exp_ch.size(); idx++) begin
      ch   = exp_ch[idx];
      last = (idx == exp_ch.size() - 1);
      check("sel_driven", 32'(sel), 32'(ch));
      check("valid_low", 32'(data_valid), 32'd0);
      check("busy_high", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
      for (int c = 1; c <= SETTLE_CYC; c++) begin
        tick();
        check("valid_timing", 32'(data_valid), 32'(c == SETTLE_CYC));
      end
      check("sample_data", 32'(data_out), 32'(mux_in[ch]));
      check("sample_chan", 32'(chan_out), 32'(ch));
      if (ch == abort_chan) begin
        noise   = 1'b0;
        start   = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("midreset");
        return;
      end
      stall = $urandom_range(stall_lo, stall_hi);
      for (int s = 0; s < stall; s++) begin
        data_ready = 1'b0;
        tick();
        check("hold_valid", 32'(data_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'(mux_in[ch]));
        check("hold_chan", 32'(chan_out), 32'(ch));
        check("hold_sel", 32'(sel), 32'(ch));
        check("hold_done", 32'(done), 32'd0);
      end
      if (last) begin
        noise = 1'b0;
        start = 1'b0;
      end
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("accept_valid", 32'(data_valid), 32'd0);
      $display("sample chan=%0d data=%0d stall=%0d", ch, mux_in[ch], stall);
      if (last) begin
        check("scan_done", 32'(done), 32'd1);
        check("scan_busy", 32'(busy), 32'd0);
        check("sel_kept", 32'(sel), 32'(ch));
        tick();
        check("done_pulse", 32'(done), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);
      end
    end
    noise = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    noise      = 1'b0;
    reset_n    = 1'b0;
    start      = 1'b0;
    chan_mask  = 4'd0;
    data_ready = 1'b0;
    for (int i = 0; i < 4; i++) mux_in[i] = DATA_W'(i + 1);
    @(negedge clock);
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();
    check_all_zero("idle");

    run_scan(4'b1111, 0, 0, 1'b0, -1);
    run_scan(4'b1010, 0, 0, 1'b0, -1);
    run_scan(4'b1111, 5, 5, 1'b0, -1);
    run_scan(4'b0000, 0, 0, 1'b0, -1);
    run_scan(4'b1111, 0, 2, 1'b1, -1);
    run_scan(4'b1111, 0, 0, 1'b0, 2);
    run_scan(4'b1101, 0, 1, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) mux_in[i] = DATA_W'($urandom);
      run_scan(4'($urandom), 0, 3, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
